unidad_fetch: RTL and testbench



---
 rtl/unidad_fetch.sv | 122 ++++++++++++
 tb/tb_unidad_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction-fetch stage.
//   Holds the program counter, presents it on `dir` to the instruction
//   memory, and registers the returned word into the IF/ID pipeline
//   register. Next-PC selection is jump > branch > stall > sequential.
//   Sticky error flags report misaligned branch targets and fetches beyond
//   the instruction memory, and a counter tracks valid IF/ID loads.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   dir                 byte address to instruction memory (= PC)
//   instruccion_in      instruction word for `dir`, same cycle
//   stall               hold PC and IF/ID
//   branch_taken        redirect to branch_target (word aligned)
//   branch_target       branch destination byte address
//   jump                redirect to {pc4[31:28], jump_index, 2'b00}
//   jump_index          J-format target field
//   if_id_instr         registered instruction for decode
//   if_id_pc4           registered PC+4 of that instruction
//   if_id_valid         IF/ID holds a real instruction
//   misalign_err        sticky: branch target had nonzero low bits
//   range_err           sticky: fetched at PC >= MEM_BYTES
//   fetch_count         count of valid IF/ID loads
module unidad_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] dir,
  input  logic [31:0] instruccion_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        range_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MemLimit = MEM_BYTES;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        range_q, range_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc4;

  always_comb begin
    pc4        = pc_q + 32'd4;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    range_d    = range_q;
    count_d    = count_q;

    if (jump) begin
      pc_d    = {pc4[31:28], jump_index, 2'b00};
      instr_d = NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (branch_taken) begin
      // Low bits are dropped so PC stays aligned; the flag records the fault.
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = NOP;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (branch_target[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (!stall) begin
      pc_d = pc4;
      if (pc_q < MemLimit) begin
        instr_d = instruccion_in;
        pc4_d   = pc4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end else begin
        // PC keeps advancing, but nothing real enters the pipeline.
        instr_d = NOP;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        range_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
      count_q    <= count_d;
    end
  end

  assign dir          = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_unidad_fetch.sv
module tb_unidad_fetch;

  localparam logic [31:0] MEMB = 32'd4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dir;
  logic [31:0] instruccion_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis, m_rng;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h11;
    if (a == 32'd4) return 32'h22;
    if (a == 32'd8) return 32'h33;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign instruccion_in = mem_word(dir);

  unidad_fetch dut (
    .clk(clk), .reset(reset), .dir(dir), .instruccion_in(instruccion_in),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err), .range_err(range_err),
    .fetch_count(fetch_count)
  );

  // Reference model: applies the fetch-stage rules to one clock edge.
  task automatic model_edge();
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    if (reset) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_mis = 1'b0; m_rng = 1'b0; m_cnt = 32'd0;
    end else if (jump) begin
      m_pc = (nxt & 32'hF000_0000) | ({6'd0, jump_index} << 2);
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (branch_taken) begin
      if (branch_target % 4 != 0) m_mis = 1'b1;
      m_pc = branch_target - (branch_target % 4);
      m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (!stall) begin
      if (m_pc < MEMB) begin
        m_instr = mem_word(m_pc); m_pc4 = nxt; m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_rng = 1'b1;
      end
      m_pc = nxt;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [31:0] bt, input logic j, input logic [25:0] ji);
    reset = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_index = ji;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0042, 1'b1, 26'h3FF_FFFF);
    tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp += 7;
    if (dir !== 32'd0) begin n_bad++; $display("FAIL reset_dir got %h want 0", dir); end
    if (if_id_instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr got %h want 0", if_id_instr); end
    if (if_id_pc4 !== 32'd0) begin n_bad++; $display("FAIL reset_pc4 got %h want 0", if_id_pc4); end
    if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
    if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b want 0", misalign_err); end
    if (range_err !== 1'b0) begin n_bad++; $display("FAIL reset_rng got %b want 0", range_err); end
    if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", fetch_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp += 4;
      if (dir !== 32'(4 * (k + 1))) begin n_bad++; $display("FAIL seq_dir%0d got %h want %h", k, dir, 4 * (k + 1)); end
      if (if_id_instr !== exp_i[k]) begin n_bad++; $display("FAIL seq_instr%0d got %h want %h", k, if_id_instr, exp_i[k]); end
      if (if_id_pc4 !== 32'(4 * (k + 1))) begin n_bad++; $display("FAIL seq_pc4%0d got %h want %h", k, if_id_pc4, 4 * (k + 1)); end
      if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid%0d got %b want 1", k, if_id_valid); end
    end
    n_cmp++;
    if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL seq_cnt got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp += 3;
      if (dir !== 32'd12) begin n_bad++; $display("FAIL stall_dir%0d got %h want c", k, dir); end
      if (if_id_instr !== 32'h33) begin n_bad++; $display("FAIL stall_instr%0d got %h want 33", k, if_id_instr); end
      if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL stall_cnt%0d got %0d want 3", k, fetch_count); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    n_cmp += 3;
    if (if_id_instr !== mem_word(32'd12)) begin n_bad++; $display("FAIL stall_rel_instr got %h want %h", if_id_instr, mem_word(32'd12)); end
    if (if_id_pc4 !== 32'd16) begin n_bad++; $display("FAIL stall_rel_pc4 got %h want 10", if_id_pc4); end
    if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL stall_rel_cnt got %0d want 4", fetch_count); end
  endtask

  task automatic test_branch();
    n_cmp++;
    if (dir !== 32'h10) begin n_bad++; $display("FAIL br_start_dir got %h want 10", dir); end
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 26'd0);  // stall ignored under redirect
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp += 3;
    if (dir !== 32'h40) begin n_bad++; $display("FAIL br_dir got %h want 40", dir); end
    if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL br_bubble got %b want 0", if_id_valid); end
    if (if_id_instr !== 32'd0) begin n_bad++; $display("FAIL br_nop got %h want 0", if_id_instr); end
    tick();
    n_cmp += 3;
    if (if_id_instr !== mem_word(32'h40)) begin n_bad++; $display("FAIL br_tgt_instr got %h want %h", if_id_instr, mem_word(32'h40)); end
    if (if_id_pc4 !== 32'h44) begin n_bad++; $display("FAIL br_tgt_pc4 got %h want 44", if_id_pc4); end
    if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL br_tgt_valid got %b want 1", if_id_valid); end
  endtask

  task automatic test_misalign();
    n_cmp++;
    if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_pre got %b want 0", misalign_err); end
    drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp += 2;
    if (dir !== 32'h40) begin n_bad++; $display("FAIL mis_dir got %h want 40", dir); end
    if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_set got %b want 1", misalign_err); end
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick(); tick();
    n_cmp++;
    if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_sticky got %b want 1", misalign_err); end
  endtask

  task automatic test_jump();
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 26'd0);
    tick();
    // Jump and branch together: jump target from pc4 = 0x1000_0008.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 26'h10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp += 2;
    if (dir !== 32'h1000_0040) begin n_bad++; $display("FAIL jmp_dir got %h want 10000040", dir); end
    if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL jmp_bubble got %b want 0", if_id_valid); end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp++;
    if (dir !== 32'h1FFF_FFFC) begin n_bad++; $display("FAIL jmp_max_dir got %h want 1ffffffc", dir); end
  endtask

  task automatic test_range();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, MEMB - 32'd8, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick(); tick();
    n_cmp += 3;
    if (dir !== MEMB) begin n_bad++; $display("FAIL rng_dir got %h want %h", dir, MEMB); end
    if (fetch_count !== 32'd2) begin n_bad++; $display("FAIL rng_cnt_in got %0d want 2", fetch_count); end
    if (range_err !== 1'b0) begin n_bad++; $display("FAIL rng_early got %b want 0", range_err); end
    tick();
    n_cmp += 4;
    if (range_err !== 1'b1) begin n_bad++; $display("FAIL rng_set got %b want 1", range_err); end
    if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rng_valid got %b want 0", if_id_valid); end
    if (fetch_count !== 32'd2) begin n_bad++; $display("FAIL rng_cnt_hold got %0d want 2", fetch_count); end
    if (dir !== MEMB + 32'd4) begin n_bad++; $display("FAIL rng_adv got %h want %h", dir, MEMB + 32'd4); end
    drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    n_cmp++;
    if (range_err !== 1'b1) begin n_bad++; $display("FAIL rng_sticky got %b want 1", range_err); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    n_cmp++;
    if (dir !== 32'd0) begin n_bad++; $display("FAIL wrap_dir got %h want 0", dir); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h43, 1'b1, 26'h55);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    n_cmp += 5;
    if (dir !== 32'd0) begin n_bad++; $display("FAIL rst_stall_dir got %h want 0", dir); end
    if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_valid got %b want 0", if_id_valid); end
    if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL rst_stall_mis got %b want 0", misalign_err); end
    if (range_err !== 1'b0) begin n_bad++; $display("FAIL rst_stall_rng got %b want 0", range_err); end
    if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL rst_stall_cnt got %0d want 0", fetch_count); end
  endtask

  task automatic test_random();
    logic [31:0] bt;
    for (int k = 0; k < 400; k++) begin
      bt = 32'($urandom_range(0, 1030)) * 32'd4;
      if ($urandom % 10 == 0) bt = bt | 32'($urandom_range(1, 3));
      drive(($urandom % 80) == 0, ($urandom % 4) == 0, ($urandom % 9) == 0, bt,
            ($urandom % 25) == 0, 26'($urandom));
      tick();
      n_cmp += 7;
      if (dir !== m_pc) begin n_bad++; $display("FAIL rnd_dir@%0d got %h want %h", k, dir, m_pc); end
      if (if_id_instr !== m_instr) begin n_bad++; $display("FAIL rnd_instr@%0d got %h want %h", k, if_id_instr, m_instr); end
      if (if_id_pc4 !== m_pc4) begin n_bad++; $display("FAIL rnd_pc4@%0d got %h want %h", k, if_id_pc4, m_pc4); end
      if (if_id_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid@%0d got %b want %b", k, if_id_valid, m_valid); end
      if (misalign_err !== m_mis) begin n_bad++; $display("FAIL rnd_mis@%0d got %b want %b", k, misalign_err, m_mis); end
      if (range_err !== m_rng) begin n_bad++; $display("FAIL rnd_rng@%0d got %b want %b", k, range_err, m_rng); end
      if (fetch_count !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt@%0d got %0d want %0d", k, fetch_count, m_cnt); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  initial begin
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_cnt = 32'd0;
    m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misalign();
    test_jump();
    test_range();
    test_wrap();
    test_reset_mid_stall();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
